sr_prog_loader: RTL and testbench

Program loader placed upstream of the CPU core and its instruction memory. Receives a byte stream (from UART RX or a testbench) over a valid/ready handshake and assembles little-endian 32-bit words. Writes them into the instruction memory write port and holds the CPU in reset while a load is in progress. After the last word is written, the CPU is released to execute the new program from address 0.

---
 rtl/sr_prog_loader.sv | 144 ++++++++++++++
 tb/tb_sr_prog_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_prog_loader.sv
// Program loader: assembles little-endian words from a byte stream, writes them into
// instruction memory and holds the CPU in reset while loading. Option: SR_LOADER_CHECKSUM_EN.
module sr_prog_loader #(
    parameter int         ADDR_WIDTH = 6,
    parameter logic [7:0] SYNC_BYTE  = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  imWe,
    output logic [ADDR_WIDTH-1:0] imWAddr,
    output logic [31:0]           imWData,
    output logic                  cpuRst_n,
    output logic                  busy,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_DONE
`ifdef SR_LOADER_CHECKSUM_EN
        , S_CHECK
        , S_ERROR
`endif
    } state_t;

    // State entered once the payload is complete (or N==0).
`ifdef SR_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHECK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [15:0] word_cnt_reg;
    logic [1:0]  byte_idx_reg;
    logic [31:0] word_reg;
    logic        accept;

`ifdef SR_LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg;
`endif

    assign accept = inValid & inReady;

    // All outputs decode from registers only; nothing flows straight from the inputs.
    assign inReady  = (state_reg != S_WRITE) && (state_reg != S_DONE);
    assign cpuRst_n = (state_reg == S_IDLE);
    assign imWe     = (state_reg == S_WRITE);
    assign imWAddr  = word_cnt_reg[ADDR_WIDTH-1:0];
    assign imWData  = word_reg;

`ifdef SR_LOADER_CHECKSUM_EN
    assign busy  = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign error = (state_reg == S_ERROR);
`else
    assign busy  = (state_reg != S_IDLE);
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= 16'd0;
            word_cnt_reg <= 16'd0;
            byte_idx_reg <= 2'd0;
            word_reg     <= 32'd0;
`ifdef SR_LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept && inData == SYNC_BYTE) begin
                        state_reg    <= S_CNT_LO;
                        word_cnt_reg <= 16'd0;
                        byte_idx_reg <= 2'd0;
`ifdef SR_LOADER_CHECKSUM_EN
                        csum_reg     <= 8'd0;
`endif
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count_reg[7:0] <= inData;
                        state_reg      <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count_reg[15:8] <= inData;
                        if ({inData, count_reg[7:0]} == 16'd0)
                            state_reg <= S_AFTER_DATA;
                        else
                            state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // Shift right so the first byte of the word ends up in [7:0].
                        word_reg     <= {inData, word_reg[31:8]};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef SR_LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ inData;
`endif
                        if (byte_idx_reg == 2'd3)
                            state_reg <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_cnt_reg <= word_cnt_reg + 16'd1;
                    if (word_cnt_reg + 16'd1 == count_reg)
                        state_reg <= S_AFTER_DATA;
                    else
                        state_reg <= S_DATA;
                end
`ifdef SR_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept)
                        state_reg <= (inData == csum_reg) ? S_DONE : S_ERROR;
                end
                S_ERROR: begin
                    if (accept && inData == SYNC_BYTE) begin
                        state_reg    <= S_CNT_LO;
                        word_cnt_reg <= 16'd0;
                        byte_idx_reg <= 2'd0;
                        csum_reg     <= 8'd0;
                    end
                end
`endif
                S_DONE: state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_prog_loader.sv
// Bench for sr_prog_loader: table-driven frame, scoreboarded writes on a default-width
// instance and a 4-word-deep instance sharing one stream, plus reset/count/gap corners.
module tb_sr_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        ready_a, we_a, cpu_a, busy_a, err_a;
    logic [5:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        ready_b, we_b, cpu_b, busy_b, err_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t ea, eb;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
        logic       cpu;
        logic       busy;
        logic       we;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] words[8];

    sr_prog_loader #(.ADDR_WIDTH(6), .SYNC_BYTE(8'h5A)) dut_a (
        .clk(clk), .rst_n(rst_n), .inData(in_data), .inValid(in_valid),
        .inReady(ready_a), .imWe(we_a), .imWAddr(waddr_a), .imWData(wdata_a),
        .cpuRst_n(cpu_a), .busy(busy_a), .error(err_a)
    );

    sr_prog_loader #(.ADDR_WIDTH(2), .SYNC_BYTE(8'h5A)) dut_b (
        .clk(clk), .rst_n(rst_n), .inData(in_data), .inValid(in_valid),
        .inReady(ready_b), .imWe(we_b), .imWAddr(waddr_b), .imWData(wdata_b),
        .cpuRst_n(cpu_b), .busy(busy_b), .error(err_b)
    );

    always #5 clk = ~clk;

    // Write scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        if (we_a) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL write_a unexpected: addr=%0d data=%h", waddr_a, wdata_a);
            end else begin
                ea = q_a.pop_front();
                if (waddr_a !== ea.addr || wdata_a !== ea.data) begin
                    n_fail++;
                    $display("FAIL write_a: got addr=%0d data=%h, want addr=%0d data=%h",
                             waddr_a, wdata_a, ea.addr, ea.data);
                end else
                    $display("[TB] write_a addr=%0d data=%h ok", waddr_a, wdata_a);
            end
        end
        if (we_b) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL write_b unexpected: addr=%0d data=%h", waddr_b, wdata_b);
            end else begin
                eb = q_b.pop_front();
                if (waddr_b !== eb.addr[1:0] || wdata_b !== eb.data) begin
                    n_fail++;
                    $display("FAIL write_b: got addr=%0d data=%h, want addr=%0d data=%h",
                             waddr_b, wdata_b, eb.addr[1:0], eb.data);
                end else
                    $display("[TB] write_b addr=%0d data=%h ok", waddr_b, wdata_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        guard = 0;
        while (!ready_a && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h never accepted", b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input int n, input int maxgap, input bit bad);
        logic [7:0]  cs;
        logic [15:0] n16;
        cs  = 8'h00;
        n16 = 16'(n);
        send_byte(8'h5A, pick_gap(maxgap));
        send_byte(n16[7:0], pick_gap(maxgap));
        send_byte(n16[15:8], pick_gap(maxgap));
        for (int i = 0; i < n; i++) begin
            q_a.push_back('{addr: 6'(i % 64), data: words[i]});
            q_b.push_back('{addr: 6'(i % 4), data: words[i]});
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ words[i][8*k +: 8];
                send_byte(words[i][8*k +: 8], pick_gap(maxgap));
            end
        end
`ifdef SR_LOADER_CHECKSUM_EN
        send_byte(bad ? 8'h00 : cs, pick_gap(maxgap));
`else
        if (bad) $display("[TB] checksum byte not sent (feature not built), csum=%h", cs);
`endif
    endtask

    task automatic wait_release(input string name);
        int c;
        c = 0;
        while (!cpu_a && c < 100) begin
            tick();
            c++;
        end
        check(name, {31'd0, cpu_a}, 32'd1);
        check({name, "_b"}, {31'd0, cpu_b}, 32'd1);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        check("rst_cpu",   {31'd0, cpu_a},   32'd1);
        check("rst_we",    {31'd0, we_a},    32'd0);
        check("rst_addr",  {26'd0, waddr_a}, 32'd0);
        check("rst_data",  wdata_a,          32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_err",   {31'd0, err_a},   32'd0);
        check("rst_cpu_b", {31'd0, cpu_b},   32'd1);
        $display("[TB] reset checked");
        rst_n = 1'b1;
        tick();

        // Idle bytes discarded
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        tick();
        check("idle_cpu",  {31'd0, cpu_a},  32'd1);
        check("idle_busy", {31'd0, busy_a}, 32'd0);
        $display("[TB] idle bytes discarded");

        // Table-driven reference frame, cycle by cycle
        q_a.push_back('{addr: 6'd0, data: 32'h00100513});
        q_a.push_back('{addr: 6'd1, data: 32'h00000463});
        q_b.push_back('{addr: 6'd0, data: 32'h00100513});
        q_b.push_back('{addr: 6'd1, data: 32'h00000463});
        vecs.push_back('{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h63, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
`ifdef SR_LOADER_CHECKSUM_EN
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h61, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            in_data  = vecs[i].data;
            in_valid = vecs[i].valid;
            tick();
            check($sformatf("vec%0d_ready", i), {31'd0, ready_a}, {31'd0, vecs[i].ready});
            check($sformatf("vec%0d_cpu", i),   {31'd0, cpu_a},   {31'd0, vecs[i].cpu});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy_a},  {31'd0, vecs[i].busy});
            check($sformatf("vec%0d_we", i),    {31'd0, we_a},    {31'd0, vecs[i].we});
            $display("[TB] vec %0d in=%h v=%b -> rdy=%b cpu=%b busy=%b we=%b",
                     i, vecs[i].data, vecs[i].valid, ready_a, cpu_a, busy_a, we_a);
        end
        in_valid = 1'b0;
        tick();
        check("frame1_drain_a", q_a.size(), 32'd0);
        check("frame1_drain_b", q_b.size(), 32'd0);

        words[0] = 32'h00100513;
        words[1] = 32'h00000463;
`ifdef SR_LOADER_CHECKSUM_EN
        // Bad checksum: error held, CPU kept in reset, then recovery
        send_frame(2, 0, 1'b1);
        tick();
        tick();
        check("err_flag", {31'd0, err_a},  32'd1);
        check("err_cpu",  {31'd0, cpu_a},  32'd0);
        check("err_busy", {31'd0, busy_a}, 32'd0);
        send_frame(2, 0, 1'b0);
        tick();
        check("recover_err", {31'd0, err_a}, 32'd0);
        wait_release("recover_cpu");
        $display("[TB] checksum error and recovery done");
`endif

        // Count zero
        send_frame(0, 0, 1'b0);
        wait_release("cnt0_release");
        check("cnt0_err", {31'd0, err_a}, 32'd0);
        $display("[TB] zero-count frame done");

        // Five words: the 4-deep instance wraps to address 0
        for (int i = 0; i < 5; i++) words[i] = $urandom();
        send_frame(5, 0, 1'b0);
        wait_release("wrap_release");
        check("wrap_drain_a", q_a.size(), 32'd0);
        check("wrap_drain_b", q_b.size(), 32'd0);
        $display("[TB] five-word wrap frame done");

        // Reset after two data bytes aborts without writing
        send_byte(8'h5A, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst_n = 1'b0;
        tick();
        check("abort_cpu",   {31'd0, cpu_a},   32'd1);
        check("abort_busy",  {31'd0, busy_a},  32'd0);
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        check("abort_we",    {31'd0, we_a},    32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        $display("[TB] mid-load reset done");

        // Random handshake gaps give the same writes
        words[0] = 32'h00100513;
        words[1] = 32'h00000463;
        words[2] = 32'hDEADBEEF;
        send_frame(3, 3, 1'b0);
        wait_release("gap_release");
        check("gap_drain_a", q_a.size(), 32'd0);
        check("gap_drain_b", q_b.size(), 32'd0);
        $display("[TB] gapped frame done");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
